// File: rtl/mips_cpu_harvard_core.sv
// mips_cpu_harvard_core
// Single-cycle Harvard MIPS32 integer core with a branch delay slot.
// Executes one instruction per enabled rising edge from RESET_VECTOR. It halts
// (active=0) on the edge that loads PC=0, and stays halted until reset.
//
// Ports:
//   clk             system clock, all state updates on the rising edge
//   rst             asynchronous active-low reset
//   clk_enable      when low, all state holds and stores are suppressed
//   active          high while executing, low once halted
//   register_v0     live value of GPR $2
//   instr_address   current PC
//   instr_readdata  instruction at instr_address (combinational memory)
//   data_address    load/store byte address, GPR[rs] + sext(imm16)
//   data_write      store strobe, memory writes on the rising edge
//   data_read       load strobe
//   data_writedata  GPR[rt] for SW
//   data_readdata   word at data_address (combinational memory)
//
// Optional build macro MULT_DIV_EN adds the HI/LO registers and the
// MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO instructions.

module mips_cpu_harvard_core #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_enable,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                           OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06,
                           OP_BGTZ = 6'h07, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                           OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23,
                           OP_SW = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03,
                           F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07,
                           F_JR = 6'h08, F_JALR = 6'h09, F_ADDU = 6'h21,
                           F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                           F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A,
                           F_SLTU = 6'h2B;
`ifdef MULT_DIV_EN
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12,
                           F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19,
                           F_DIV = 6'h1A, F_DIVU = 6'h1B;
`endif

    logic [31:0] r_pc;
    logic [31:0] r_next_pc;   // PC of the instruction after the current one
    logic        r_active;
    logic [31:0] r_gpr [0:31];
`ifdef MULT_DIV_EN
    logic [31:0] r_hi, r_lo;
    logic [31:0] w_hi_next, w_lo_next;
`endif

    // Instruction fields
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm;
    logic [31:0] w_rs_val, w_rt_val, w_sext, w_zext;
    logic [31:0] w_pc_plus4, w_pc_plus8, w_br_target, w_j_target;

    assign w_op       = instr_readdata[31:26];
    assign w_rs       = instr_readdata[25:21];
    assign w_rt       = instr_readdata[20:16];
    assign w_rd       = instr_readdata[15:11];
    assign w_shamt    = instr_readdata[10:6];
    assign w_funct    = instr_readdata[5:0];
    assign w_imm      = instr_readdata[15:0];
    assign w_rs_val   = r_gpr[w_rs];
    assign w_rt_val   = r_gpr[w_rt];
    assign w_sext     = {{16{w_imm[15]}}, w_imm};
    assign w_zext     = {16'h0000, w_imm};
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_plus8 = r_pc + 32'd8;
    assign w_br_target = w_pc_plus4 + {w_sext[29:0], 2'b00};
    assign w_j_target  = {w_pc_plus4[31:28], instr_readdata[25:0], 2'b00};

    // Decode / execute results
    logic        w_wr_en, w_taken, w_is_lw, w_is_sw;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data, w_target;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        w_wr_en   = 1'b0;
        w_wr_addr = w_rd;
        w_wr_data = 32'h0;
        w_taken   = 1'b0;
        w_target  = w_br_target;
        w_is_lw   = 1'b0;
        w_is_sw   = 1'b0;
`ifdef MULT_DIV_EN
        w_hi_next = r_hi;
        w_lo_next = r_lo;
`endif
        case (w_op)
            OP_SPECIAL: begin
                w_wr_en = 1'b1;
                case (w_funct)
                    F_SLL:  w_wr_data = w_rt_val << w_shamt;
                    F_SRL:  w_wr_data = w_rt_val >> w_shamt;
                    F_SRA:  w_wr_data = $signed(w_rt_val) >>> w_shamt;
                    F_SLLV: w_wr_data = w_rt_val << w_rs_val[4:0];
                    F_SRLV: w_wr_data = w_rt_val >> w_rs_val[4:0];
                    F_SRAV: w_wr_data = $signed(w_rt_val) >>> w_rs_val[4:0];
                    F_ADDU: w_wr_data = w_rs_val + w_rt_val;
                    F_SUBU: w_wr_data = w_rs_val - w_rt_val;
                    F_AND:  w_wr_data = w_rs_val & w_rt_val;
                    F_OR:   w_wr_data = w_rs_val | w_rt_val;
                    F_XOR:  w_wr_data = w_rs_val ^ w_rt_val;
                    F_NOR:  w_wr_data = ~(w_rs_val | w_rt_val);
                    F_SLT:  w_wr_data = {31'h0, $signed(w_rs_val) < $signed(w_rt_val)};
                    F_SLTU: w_wr_data = {31'h0, w_rs_val < w_rt_val};
                    F_JR: begin
                        w_wr_en  = 1'b0;
                        w_taken  = 1'b1;
                        w_target = w_rs_val;
                    end
                    F_JALR: begin
                        w_taken   = 1'b1;
                        w_target  = w_rs_val;
                        w_wr_data = w_pc_plus8;
                    end
`ifdef MULT_DIV_EN
                    F_MFHI: w_wr_data = r_hi;
                    F_MFLO: w_wr_data = r_lo;
                    F_MTHI: begin w_wr_en = 1'b0; w_hi_next = w_rs_val; end
                    F_MTLO: begin w_wr_en = 1'b0; w_lo_next = w_rs_val; end
                    F_MULT: begin
                        w_wr_en = 1'b0;
                        {w_hi_next, w_lo_next} = $signed({{32{w_rs_val[31]}}, w_rs_val})
                                               * $signed({{32{w_rt_val[31]}}, w_rt_val});
                    end
                    F_MULTU: begin
                        w_wr_en = 1'b0;
                        {w_hi_next, w_lo_next} = {32'h0, w_rs_val} * {32'h0, w_rt_val};
                    end
                    F_DIV: begin
                        w_wr_en = 1'b0;
                        if (w_rt_val != 32'h0) begin
                            w_lo_next = $signed(w_rs_val) / $signed(w_rt_val);
                            w_hi_next = $signed(w_rs_val) % $signed(w_rt_val);
                        end
                    end
                    F_DIVU: begin
                        w_wr_en = 1'b0;
                        if (w_rt_val != 32'h0) begin
                            w_lo_next = w_rs_val / w_rt_val;
                            w_hi_next = w_rs_val % w_rt_val;
                        end
                    end
`endif
                    default: w_wr_en = 1'b0;
                endcase
            end
            OP_J:    begin w_taken = 1'b1; w_target = w_j_target; end
            OP_JAL: begin
                w_taken   = 1'b1;
                w_target  = w_j_target;
                w_wr_en   = 1'b1;
                w_wr_addr = 5'd31;
                w_wr_data = w_pc_plus8;
            end
            OP_BEQ:  w_taken = (w_rs_val == w_rt_val);
            OP_BNE:  w_taken = (w_rs_val != w_rt_val);
            OP_BLEZ: w_taken = ($signed(w_rs_val) <= 0);
            OP_BGTZ: w_taken = ($signed(w_rs_val) > 0);
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                w_wr_en   = 1'b1;
                w_wr_addr = w_rt;
                case (w_op)
                    OP_ADDIU: w_wr_data = w_rs_val + w_sext;
                    OP_SLTI:  w_wr_data = {31'h0, $signed(w_rs_val) < $signed(w_sext)};
                    OP_SLTIU: w_wr_data = {31'h0, w_rs_val < w_sext};
                    OP_ANDI:  w_wr_data = w_rs_val & w_zext;
                    OP_ORI:   w_wr_data = w_rs_val | w_zext;
                    OP_XORI:  w_wr_data = w_rs_val ^ w_zext;
                    default:  w_wr_data = {w_imm, 16'h0000};
                endcase
            end
            OP_LW: begin
                w_is_lw   = 1'b1;
                w_wr_en   = 1'b1;
                w_wr_addr = w_rt;
                w_wr_data = data_readdata;
            end
            OP_SW:   w_is_sw = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_VECTOR;
            r_next_pc <= RESET_VECTOR + 32'd4;
            r_active  <= 1'b1;
            // NOTE: the register file is cleared on reset because software
            // and the checker rely on every GPR starting at zero.
            for (int i = 0; i < 32; i++) r_gpr[i] <= 32'h0;
`ifdef MULT_DIV_EN
            r_hi <= 32'h0;
            r_lo <= 32'h0;
`endif
        end else if (clk_enable && r_active) begin
            // The instruction after a branch (delay slot) is already queued in
            // r_next_pc; the branch outcome only redirects the one after it.
            r_pc      <= r_next_pc;
            r_next_pc <= w_taken ? w_target : r_next_pc + 32'd4;
            if (r_next_pc == 32'h0) r_active <= 1'b0;
            if (w_wr_en && w_wr_addr != 5'd0) r_gpr[w_wr_addr] <= w_wr_data;
`ifdef MULT_DIV_EN
            r_hi <= w_hi_next;
            r_lo <= w_lo_next;
`endif
        end
    end

    assign active         = r_active;
    assign register_v0    = r_gpr[2];
    assign instr_address  = r_pc;
    assign data_address   = w_rs_val + w_sext;
    assign data_writedata = w_rt_val;
    assign data_write     = rst & clk_enable & r_active & w_is_sw;
    assign data_read      = rst & r_active & w_is_lw;

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
`timescale 1ns/1ps
module tb_mips_cpu_harvard_core;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic [31:0] ADDIU_V0_1 = 32'h24420001;  // ADDIU $2,$2,1

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_enable = 1'b1;
    logic        active;
    logic [31:0] register_v0;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    always #5 clk = ~clk;

    mips_cpu_harvard_core #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .active(active),
        .register_v0(register_v0), .instr_address(instr_address),
        .instr_readdata(instr_readdata), .data_address(data_address),
        .data_write(data_write), .data_read(data_read),
        .data_writedata(data_writedata), .data_readdata(data_readdata)
    );

    // Memories: program at RV, ADDIU $2,$2,1 at address 0 so a core that
    // keeps running after the halt would visibly change v0.
    logic [31:0] prog [0:31];
    logic [31:0] dmem [0:63];
    logic [31:0] off;
    int          prog_n;

    always_comb begin
        off = instr_address - RV;
        instr_readdata = 32'h0;
        if (instr_address == 32'h0) instr_readdata = ADDIU_V0_1;
        else if (off < 32'd128) instr_readdata = prog[off[6:2]];
    end

    assign data_readdata = dmem[data_address[7:2]];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
        end else if (data_write) begin
            dmem[data_address[7:2]] <= data_writedata;
        end
    end

    // Scoreboard
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;
    st_t         st_q [$];
    logic [31:0] v0_q [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Store monitor: outputs are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        st_t e;
        if (rst && data_write) begin
            check("st_count", 32'(st_q.size() > 0), 32'd1);
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                check("st_addr", data_address, e.addr);
                check("st_data", data_writedata, e.data);
            end
        end
    end

    // Encoders
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        enc_i = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        enc_r = {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction
    function automatic logic [31:0] enc_j(input int op, input logic [31:0] addr);
        enc_j = {op[5:0], addr[27:2]};
    endfunction

    task automatic new_prog();
        for (int i = 0; i < 32; i++) prog[i] = 32'h0;
        prog_n = 0;
    endtask
    task automatic emit(input logic [31:0] w);
        prog[prog_n] = w;
        prog_n++;
    endtask
    task automatic exp_st(input logic [31:0] a, input logic [31:0] d);
        st_q.push_back('{addr: a, data: d});
    endtask
    task automatic halt_seq();
        emit(enc_r(0, 0, 0, 0, 8'h08));  // JR $0
        emit(32'h0);                     // delay slot NOP
    endtask

    // Reset, run until halt (bounded), optionally stall 5 cycles after
    // stall_at enabled edges, then check the result and the frozen state.
    task automatic run_prog(input string name, input logic [31:0] exp_v0,
                            input int exp_cycles, input int stall_at);
        int          cyc;
        logic [31:0] pc_hold, v0_hold, v0_exp;
        v0_q.push_back(exp_v0);
        rst = 1'b0;
        clk_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check({name, ":rst_pc"}, instr_address, RV);
        check({name, ":rst_active"}, {31'h0, active}, 32'd1);
        check({name, ":rst_v0"}, register_v0, 32'h0);
        check({name, ":rst_strobes"}, {30'h0, data_write, data_read}, 32'h0);
        rst = 1'b1;
        cyc = 0;
        while (active && cyc < 200) begin
            if (cyc == stall_at) begin
                pc_hold = instr_address;
                v0_hold = register_v0;
                clk_enable = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check({name, ":stall_pc"}, instr_address, pc_hold);
                    check({name, ":stall_v0"}, register_v0, v0_hold);
                    check({name, ":stall_wr"}, {31'h0, data_write}, 32'h0);
                end
                clk_enable = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, ":halted"}, {31'h0, active}, 32'h0);
        check({name, ":cycles"}, 32'(cyc), 32'(exp_cycles));
        v0_exp = v0_q.pop_front();
        check({name, ":v0"}, register_v0, v0_exp);
        check({name, ":halt_pc"}, instr_address, 32'h0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check({name, ":frozen_v0"}, register_v0, v0_exp);
        check({name, ":frozen_pc"}, instr_address, 32'h0);
        check({name, ":frozen_strobes"}, {30'h0, data_write, data_read}, 32'h0);
        check({name, ":stores_left"}, 32'(st_q.size()), 32'h0);
        st_q.delete();
    endtask

    initial begin
        // ADDIU then JR $0 with the delay slot still committing
        new_prog();
        emit(enc_i(8'h09, 0, 2, 5));
        emit(enc_r(0, 0, 0, 0, 8'h08));
        emit(enc_i(8'h09, 2, 2, 1));
        run_prog("addiu_jr", 32'd6, 3, -1);

        // Store then load, stalled while the SW is the current instruction
        new_prog();
        emit(enc_i(8'h0F, 0, 3, 16'h1234));
        emit(enc_i(8'h0D, 3, 3, 16'hABCD));
        emit(enc_i(8'h2B, 0, 3, 8));
        emit(enc_i(8'h23, 0, 2, 8));
        halt_seq();
        exp_st(32'd8, 32'h1234ABCD);
        run_prog("sw_lw_stall", 32'h1234ABCD, 6, 2);

        // BEQ taken: delay slot runs, next instruction skipped
        new_prog();
        emit(enc_i(8'h09, 0, 2, 1));
        emit(enc_i(8'h04, 0, 0, 2));
        emit(enc_i(8'h09, 2, 2, 1));
        emit(enc_i(8'h09, 2, 2, 1));
        halt_seq();
        run_prog("beq_taken", 32'd2, 5, -1);

        // Same program stalled while the branch is pending in the delay slot
        run_prog("beq_stall", 32'd2, 5, 2);

        // BNE untaken: falls through to PC+8
        new_prog();
        emit(enc_i(8'h09, 0, 2, 1));
        emit(enc_i(8'h05, 0, 0, 5));
        emit(enc_i(8'h09, 2, 2, 1));
        emit(enc_i(8'h09, 2, 2, 4));
        halt_seq();
        run_prog("bne_untaken", 32'd6, 6, -1);

        // Arithmetic corners, observed through stores
        new_prog();
        emit(enc_i(8'h0F, 0, 2, 16'hFFFF));        // LUI $2,0xFFFF
        emit(enc_i(8'h0D, 2, 2, 16'hFFFF));        // ORI $2,$2,0xFFFF
        emit(enc_i(8'h2B, 0, 2, 0));               exp_st(32'd0, 32'hFFFFFFFF);
        emit(enc_i(8'h09, 2, 3, 1));               // ADDIU wraps
        emit(enc_i(8'h2B, 0, 3, 4));               exp_st(32'd4, 32'h0);
        emit(enc_i(8'h09, 0, 4, 1));
        emit(enc_r(2, 4, 5, 0, 8'h2A));            // SLT(-1,1)
        emit(enc_i(8'h2B, 0, 5, 8));               exp_st(32'd8, 32'd1);
        emit(enc_r(2, 4, 6, 0, 8'h2B));            // SLTU(-1,1)
        emit(enc_i(8'h2B, 0, 6, 12));              exp_st(32'd12, 32'd0);
        emit(enc_i(8'h0F, 0, 7, 16'h8000));
        emit(enc_r(0, 7, 8, 4, 8'h03));            // SRA by 4
        emit(enc_i(8'h2B, 0, 8, 16));              exp_st(32'd16, 32'hF8000000);
        emit(enc_r(0, 7, 9, 4, 8'h02));            // SRL by 4
        emit(enc_i(8'h2B, 0, 9, 20));              exp_st(32'd20, 32'h08000000);
        emit(enc_r(4, 2, 10, 0, 8'h23));           // SUBU 1-(-1)
        emit(enc_i(8'h2B, 0, 10, 24));             exp_st(32'd24, 32'd2);
        emit(enc_r(0, 4, 11, 0, 8'h27));           // NOR
        emit(enc_i(8'h2B, 0, 11, 28));             exp_st(32'd28, 32'hFFFFFFFE);
        emit(enc_i(8'h0E, 2, 12, 16'h00FF));       // XORI zero-extended
        emit(enc_i(8'h2B, 0, 12, 32));             exp_st(32'd32, 32'hFFFFFF00);
        emit(enc_i(8'h0B, 4, 13, 16'hFFFF));       // SLTIU sign-extended imm
        emit(enc_i(8'h2B, 0, 13, 36));             exp_st(32'd36, 32'd1);
        emit(enc_i(8'h09, 0, 0, 7));               // ADDIU $0 discarded
        emit(enc_i(8'h2B, 0, 0, 40));              exp_st(32'd40, 32'h0);
        emit(enc_r(2, 4, 14, 0, 8'h04));           // SLLV by $2[4:0]=31
        emit(enc_i(8'h2B, 0, 14, 44));             exp_st(32'd44, 32'h80000000);
        emit(enc_r(14, 4, 2, 0, 8'h21));           // ADDU
        halt_seq();
        run_prog("arith", 32'h80000001, 30, -1);

        // JAL / JR $31 with link value and delay slots
        new_prog();
        emit(enc_j(8'h03, RV + 32'd20));           // 0: JAL idx5
        emit(enc_i(8'h09, 0, 2, 3));               // 1: delay slot
        emit(enc_i(8'h09, 2, 2, 100));             // 2: return point
        halt_seq();                                // 3,4
        emit(enc_i(8'h2B, 0, 31, 0));              // 5: SW $31
        emit(enc_r(31, 0, 0, 0, 8'h08));           // 6: JR $31
        emit(enc_i(8'h09, 2, 2, 10));              // 7: delay slot
        exp_st(32'd0, RV + 32'd8);
        run_prog("jal_jr", 32'd113, 8, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
